// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point FFT pipeline.
package fft_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned W     = 16;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_bank.sv
// One bank of N complex sample registers with per-slot write enables.
module frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned N = fft_pkg::N,
    parameter int unsigned W = fft_pkg::W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        we,
    input  logic signed [W-1:0] wr_re,
    input  logic signed [W-1:0] wr_im,
    output logic signed [W-1:0] R_out [0:N-1],
    output logic signed [W-1:0] I_out [0:N-1]
);

    logic signed [W-1:0] re_q [0:N-1];
    logic signed [W-1:0] im_q [0:N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (we[i]) begin
                    re_q[i] <= wr_re;
                    im_q[i] <= wr_im;
                end
            end
        end
    end

    assign R_out = re_q;
    assign I_out = im_q;

endmodule

// File: rtl/fft_input_loader.sv
// Ping-pong serial-to-parallel loader: writes samples at bit-reversed slots,
// presents completed frames in parallel on a valid/ready handshake.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int unsigned N = fft_pkg::N,
    parameter int unsigned W = fft_pkg::W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic                in_last,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic signed [W-1:0] R_out [0:N-1],
    output logic signed [W-1:0] I_out [0:N-1],
    output logic                frame_err
);

    localparam int unsigned CW = $clog2(N);

    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          err_q, err_d;

    logic          accept, consume, last_slot;
    logic [N-1:0]  slot_we, we0, we1;

    logic signed [W-1:0] b0_re [0:N-1];
    logic signed [W-1:0] b0_im [0:N-1];
    logic signed [W-1:0] b1_re [0:N-1];
    logic signed [W-1:0] b1_im [0:N-1];

    always_comb begin
        in_ready    = !full_q[wr_sel_q];
        frame_valid = full_q[rd_sel_q];
        accept      = in_valid && in_ready;
        consume     = frame_valid && frame_ready;
        last_slot   = (wr_cnt_q == CW'(N - 1));

        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = 1'b0;
        slot_we  = '0;

        // Commit and consume never target the same bank: commit needs it empty,
        // consume needs it full.
        if (consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end

        if (accept) begin
            slot_we[bitrev(wr_cnt_q)] = 1'b1;
            err_d = (in_last != last_slot);
            if (last_slot) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
                wr_cnt_d         = '0;
            end else if (in_last) begin
                wr_cnt_d = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    assign we0 = wr_sel_q ? '0 : slot_we;
    assign we1 = wr_sel_q ? slot_we : '0;

    frame_bank #(
        .N (N),
        .W (W)
    ) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (we0),
        .wr_re (in_re),
        .wr_im (in_im),
        .R_out (b0_re),
        .I_out (b0_im)
    );

    frame_bank #(
        .N (N),
        .W (W)
    ) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (we1),
        .wr_re (in_re),
        .wr_im (in_im),
        .R_out (b1_re),
        .I_out (b1_im)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            R_out[i] = rd_sel_q ? b1_re[i] : b0_re[i];
            I_out[i] = rd_sel_q ? b1_im[i] : b0_im[i];
        end
    end

    assign frame_err = err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader against a frame-queue reference model.
module tb_fft_input_loader;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int LG = $clog2(N);
    localparam int FW = 2 * N * W;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                in_last;
    logic                frame_valid;
    logic                frame_ready;
    logic signed [W-1:0] R_out [0:N-1];
    logic signed [W-1:0] I_out [0:N-1];
    logic                frame_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: completed frames held in natural sample order.
    logic [N-1:0][W-1:0] held_re [$];
    logic [N-1:0][W-1:0] held_im [$];
    logic [N-1:0][W-1:0] cur_re;
    logic [N-1:0][W-1:0] cur_im;
    int                  cnt;
    bit                  exp_err;

    always #5 clk = ~clk;

    fft_input_loader #(
        .N (N),
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .R_out       (R_out),
        .I_out       (I_out),
        .frame_err   (frame_err)
    );

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < LG; b++) begin
            if ((k >> b) % 2 == 1) r += 1 << (LG - 1 - b);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] dut_frame();
        logic [FW-1:0] o = '0;
        for (int k = 0; k < N; k++) begin
            o[k*W +: W]     = R_out[k];
            o[(N+k)*W +: W] = I_out[k];
        end
        return o;
    endfunction

    task automatic check_outputs();
        logic [FW-1:0]       e;
        logic [N-1:0][W-1:0] hr, hi;
        chk("in_ready", FW'(in_ready), FW'(held_re.size() < 2));
        chk("frame_valid", FW'(frame_valid), FW'(held_re.size() > 0));
        chk("frame_err", FW'(frame_err), FW'(exp_err));
        if (held_re.size() > 0) begin
            hr = held_re[0];
            hi = held_im[0];
            e  = '0;
            for (int k = 0; k < N; k++) begin
                e[k*W +: W]     = hr[rev(k)];
                e[(N+k)*W +: W] = hi[rev(k)];
            end
            chk("frame_data", dut_frame(), e);
        end
    endtask

    task automatic cycle(input bit v, input bit last, input bit fr,
                         input logic [W-1:0] re, input logic [W-1:0] im, output bit acc);
        bit rdy, cons;
        in_valid    = v;
        in_last     = last;
        frame_ready = fr;
        in_re       = re;
        in_im       = im;
        check_outputs();
        rdy     = held_re.size() < 2;
        cons    = (held_re.size() > 0) && fr;
        acc     = v && rdy;
        exp_err = acc && (last != (cnt == N - 1));
        if (cons) begin
            held_re.delete(0);
            held_im.delete(0);
        end
        if (acc) begin
            cur_re[cnt] = re;
            cur_im[cnt] = im;
            if (cnt == N - 1) begin
                held_re.push_back(cur_re);
                held_im.push_back(cur_im);
                cnt = 0;
            end else if (last) begin
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer n_samp samples; in_last on accepted sample index last_at (-1: never).
    task automatic send(input int n_samp, input int last_at, input bit fr, input bit ramp);
        int k = 0;
        int budget = 0;
        bit acc;
        logic [W-1:0] re, im;
        while (k < n_samp && budget < 200) begin
            re = ramp ? W'(k) : W'($urandom);
            im = ramp ? W'(-k) : W'($urandom);
            cycle(1'b1, k == last_at, fr, re, im, acc);
            if (acc) k++;
            budget++;
        end
        chk("send_budget", FW'(k), FW'(n_samp));
    endtask

    task automatic idle(input int n, input bit fr);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, fr, '0, '0, acc);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        held_re.delete();
        held_im.delete();
        cnt     = 0;
        exp_err = 1'b0;
        chk("reset_data_zero", dut_frame(), '0);
        check_outputs();
    endtask

    initial begin
        bit acc;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        in_re       = '0;
        in_im       = '0;
        cnt         = 0;
        exp_err     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Ramp frame
        send(N, N - 1, 1'b1, 1'b1);
        chk("ramp_valid", FW'(frame_valid), FW'(1));
        chk("ramp_R8", FW'($unsigned(R_out[8])), FW'(16'd1));
        chk("ramp_R12", FW'($unsigned(R_out[12])), FW'(16'd3));
        chk("ramp_I4", FW'($unsigned(I_out[4])), FW'(16'hfffe));
        chk("ramp_R15", FW'($unsigned(R_out[15])), FW'(16'd15));
        idle(2, 1'b1);

        // Back-to-back frames at full rate
        for (int f = 0; f < 4; f++) send(N, N - 1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Backpressure: two frames fill both banks, third stalls until a consume
        send(N, N - 1, 1'b0, 1'b0);
        send(N, N - 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, W'($urandom), W'($urandom), acc);
        cycle(1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom), acc);
        send(N, N - 1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Early in_last discards the partial frame; the next frame reuses the bank
        send(10, 9, 1'b0, 1'b0);
        idle(2, 1'b0);
        send(N, N - 1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Missing in_last still commits
        send(N, -1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Randomized soak with occasional misaligned in_last
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, (cnt == N - 1) ^ (($urandom % 16) == 0),
                  ($urandom % 3) != 0, W'($urandom), W'($urandom), acc);
        end
        idle(4, 1'b1);

        // Reset mid-frame with one frame held
        send(N, N - 1, 1'b0, 1'b0);
        send(7, -1, 1'b0, 1'b0);
        do_reset();
        send(N, N - 1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Serial-to-parallel front end of the 16-point FFT pipeline. Accepts one complex sample per cycle on a valid/ready stream, stores it at its bit-reversed slot, and presents a complete 16-sample frame in parallel to the first `stage_reg_bank`/butterfly stage. It is ping-pong double-buffered, so streaming continues at full rate while the previous frame is held for the downstream stage.

## Interface

Parameters:

- `N`, 16: frame length in samples; must be a power of 2.
- `W`, 16: sample width in bits, per real/imaginary part, signed two's complement.

Ports:

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: input sample valid.
- `in_ready`  out  1: loader can accept a sample this cycle.
- `in_re`, `in_im`  in  W signed: input sample.
- `in_last`  in  1: marks the final sample of a frame.
- `frame_valid`  out  1: `R_out`/`I_out` hold a complete frame.
- `frame_ready`  in  1: downstream consumes the frame.
- `R_out [0:N-1]`, `I_out [0:N-1]`  out  W signed each: frame in bit-reversed order.
- `frame_err`  out  1: one-cycle pulse on an `in_last` misalignment.

## Operation

- **State:**
  - two banks, 0 and 1, each holding N complex registers;
  - `full[1:0]`;
  - `wr_sel` and `rd_sel` (1 bit each);
  - `wr_cnt` (log2 N bits).
- **Accept:** a sample is accepted when `in_valid && in_ready`. It is written to `bank[wr_sel]` at slot `bitrev(wr_cnt)`. For N=16: n=1 goes to slot 8, n=3 to slot 12, n=15 to slot 15.
- **`in_ready`** = `!full[wr_sel]`.
- **Commit:** on an accepted sample with `wr_cnt == N-1`:
  - set `full[wr_sel]`;
  - toggle `wr_sel`;
  - reset `wr_cnt` to 0.
- **Otherwise:** `wr_cnt` increments on each accepted sample.
- **`frame_err`** pulses the cycle after an accepted sample where `in_last != (wr_cnt == N-1)`.
  - Early `in_last` (`wr_cnt < N-1`): the partial frame is discarded. `wr_cnt` resets to 0, nothing is committed, `wr_sel` is unchanged.
  - Missing `in_last` at `wr_cnt == N-1`: the frame is committed normally and `frame_err` still pulses.
- **Read side:**
  - `frame_valid` = `full[rd_sel]`.
  - `R_out`/`I_out` are driven directly from `bank[rd_sel]` registers, with no combinational path from the inputs.
  - When `frame_valid` is low, the outputs show the stale contents of `bank[rd_sel]`.
- **Consume:** on `frame_valid && frame_ready`, clear `full[rd_sel]` and toggle `rd_sel`.
- **Simultaneous commit and consume on different banks:** both updates take effect. If the other bank was already full, `frame_valid` stays high with the new bank's data the next cycle.
- **Consume of the bank currently targeted by `wr_sel`:** that bank becomes writable the next cycle (`in_ready` rises at t+1), never in the same cycle.
- **Reset:**
  - `full` = 0, `wr_sel` = `rd_sel` = 0, `wr_cnt` = 0;
  - all bank registers = 0;
  - `frame_valid` = 0, `in_ready` = 1 on the cycle after reset, `frame_err` = 0.
- **Reset mid-frame:** the partial frame and any held frames are lost; no error pulse.

## Timing

- Last sample accepted at edge t → `frame_valid` = 1 and the full frame is on `R_out`/`I_out` after edge t (visible in cycle t+1).
- Throughput is 1 sample/cycle sustained when `frame_ready` is held high: a bank is freed within N cycles of commit, so `in_ready` never drops.
- With `frame_ready` = 0:
  - the first frame fills bank 0 and the second fills bank 1;
  - `in_ready` falls after the 32nd accepted sample;
  - it rises one cycle after the first consume.
- `frame_valid` and the output data are stable until consumed; the data never changes while `frame_valid` is high and `frame_ready` is low.

## Structure

- **Shared package `fft_pkg`:** `N`, `LOG2N`, `W`, and the function `bitrev(idx)` (LOG2N-bit reversal). The later FFT stages reuse the package.
- **Sub-module `frame_bank`:** N complex registers with `clk`/`rst`, per-slot write enable, a shared write data input, and unpacked `R_out`/`I_out` arrays. It is instantiated twice (ping-pong). The top level holds the counters, flags, and output mux.

## Test plan

- **Ramp frame:** reset, then stream samples re=n, im=-n for n=0..15 with `in_last` on n=15 and `frame_ready` = 1. Required:
  - `frame_valid` at the cycle after the last accept;
  - `R_out[8]` = 1, `R_out[12]` = 3, `I_out[4]` = -2, `R_out[15]` = 15;
  - `frame_err` never high.
- **Back-to-back frames:** 4 consecutive frames with `frame_ready` = 1 throughout. Required:
  - `in_ready` constantly 1;
  - 4 `frame_valid` pulses spaced 16 cycles apart;
  - each frame's data matches its bit-reversed input.
- **Backpressure:** 3 frames streamed with `frame_ready` = 0. Required:
  - `in_ready` drops after 32 accepts;
  - after raising `frame_ready` for one cycle, the frame-0 data is replaced by frame-1 data;
  - `in_ready` = 1 on the following cycle, and the third frame then completes.
- **Early `in_last`:** assert `in_last` at n=9. Required:
  - `frame_err` pulses once;
  - no `frame_valid`;
  - the next 16 samples form a correct frame in the same bank.
- **Missing `in_last`:** 16 samples with `in_last` = 0. Required: the frame commits and `frame_err` pulses once.
- **Reset mid-frame:** assert `rst` after 7 samples with one full frame held. Required:
  - `frame_valid` = 0 and all outputs 0 after reset;
  - a fresh 16-sample frame commits normally.
